pcie_req_tlp_encoder: RTL

- Parametrised successor to the single-width config TLP encoder.
- Builds CfgRd/CfgWr (Type0 or Type1) and Msg/MsgD requests onto the PCIe core AXI4-Stream RQ interface at 64-, 128- or 256-bit data width.
- Latches each controller request through a valid/ready handshake, so the controller need not hold its inputs stable.
- Assigns rolling tags and sequence numbers, and returns the tag with a completion pulse; sits between the NVMe config controller and the RQ Tx mux.

---
 rtl/pcie_req_tlp_encoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pcie_req_tlp_encoder.sv
// Request TLP encoder: turns one latched config/message request into an RQ
// descriptor (+ optional payload DW) spread over 64/128/256-bit beats.
module pcie_req_tlp_encoder #(
    parameter logic [15:0] REQUESTER_ID        = 16'h10EE,
    parameter logic [7:0]  LOCAL_BUS           = 8'h01,
    parameter int          C_DATA_WIDTH        = 128,
    parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int          AXI4_RQ_TUSER_WIDTH = 62
) (
    input  logic                           user_clk,
    input  logic                           reset_n,
    input  logic                           pg_s_axis_rq_tready,
    output logic [C_DATA_WIDTH-1:0]        pg_s_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]          pg_s_axis_rq_tkeep,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0] pg_s_axis_rq_tuser,
    output logic                           pg_s_axis_rq_tlast,
    output logic                           pg_s_axis_rq_tvalid,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [1:0]                     req_type,
    input  logic [7:0]                     req_bus,
    input  logic [4:0]                     req_dev,
    input  logic [2:0]                     req_func,
    input  logic [9:0]                     req_reg_num,
    input  logic [3:0]                     req_1dw_be,
    input  logic [2:0]                     req_msg_routing,
    input  logic [7:0]                     req_msg_code,
    input  logic [31:0]                    req_data,
    output logic                           req_done,
    output logic [7:0]                     req_done_tag,
    output logic [1:0]                     o_dbg_state
);

    generate
        if (!(C_DATA_WIDTH == 64 || C_DATA_WIDTH == 128 || C_DATA_WIDTH == 256)) begin : g_bad_width
            $error("pcie_req_tlp_encoder: C_DATA_WIDTH must be 64, 128 or 256");
        end
    endgenerate

    localparam int DPB      = C_DATA_WIDTH / 32;
    localparam int NB_NOPAY = (4 + DPB - 1) / DPB;
    localparam int NB_PAY   = (5 + DPB - 1) / DPB;
    localparam int TLP_W    = NB_PAY * C_DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshakes: req_valid/req_ready transfer a request on a rising edge where
    // both are high; tvalid/tready transfer a beat likewise, and every RQ output
    // is held unchanged while tvalid is high and tready is low.

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [TLP_W-1:0]               r_tlp;
    logic [AXI4_RQ_TUSER_WIDTH-1:0] r_tuser;
    logic [2:0]                     r_ndw;
    logic [1:0]                     r_beat;
    logic [1:0]                     r_last_beat;
    logic                           r_is_cfg;
    logic [7:0]                     r_tag;
    logic [7:0]                     r_tag_ctr;
    logic [3:0]                     r_seq_ctr;

    logic                           w_is_cfg;
    logic                           w_has_pay;
    logic [3:0]                     w_tlp_type;
    logic [10:0]                    w_len;
    logic [TLP_W-1:0]               w_tlp;
    logic [AXI4_RQ_TUSER_WIDTH-1:0] w_tuser;
    logic [C_DATA_WIDTH-1:0]        w_beat_data;
    logic [KEEP_WIDTH-1:0]          w_keep;
    logic                           w_in_beat;

    assign w_is_cfg  = ~req_type[1];
    assign w_has_pay = req_type[0];

    // Descriptor and first-beat sideband are assembled straight from the inputs
    // so the whole packet can be captured in the accept cycle.
    always_comb begin
        w_tlp_type = 4'b1100;
        if (w_is_cfg) begin
            w_tlp_type = {2'b10, req_type[0], (req_bus != LOCAL_BUS)};
        end
        w_len = (w_is_cfg || w_has_pay) ? 11'd1 : 11'd0;

        w_tlp = '0;
        if (w_is_cfg) begin
            w_tlp[31:0]   = {20'b0, req_reg_num, 2'b00};
            w_tlp[127:96] = {8'h00, req_bus, req_dev, req_func, r_tag_ctr};
        end else begin
            w_tlp[127:96] = {8'h00, 5'b0, req_msg_routing, req_msg_code, 8'h00};
        end
        w_tlp[95:64] = {REQUESTER_ID, 1'b0, w_tlp_type, w_len};
        if (w_has_pay) begin
            w_tlp[159:128] = req_data;
        end

        w_tuser = '0;
        if (w_is_cfg) begin
            w_tuser[3:0] = req_1dw_be;
        end
        w_tuser[27:24] = r_seq_ctr;
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_tlp       <= '0;
            r_tuser     <= '0;
            r_ndw       <= '0;
            r_beat      <= '0;
            r_last_beat <= '0;
            r_is_cfg    <= 1'b0;
            r_tag       <= '0;
            r_tag_ctr   <= '0;
            r_seq_ctr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_tlp       <= w_tlp;
                        r_tuser     <= w_tuser;
                        r_ndw       <= w_has_pay ? 3'd5 : 3'd4;
                        r_last_beat <= w_has_pay ? 2'(NB_PAY - 1) : 2'(NB_NOPAY - 1);
                        r_beat      <= '0;
                        r_is_cfg    <= w_is_cfg;
                        r_tag       <= w_is_cfg ? r_tag_ctr : 8'h00;
                    end
                end
                S_BEAT: begin
                    if (pg_s_axis_rq_tready && (r_beat != r_last_beat)) begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                S_DONE: begin
                    // Only non-posted requests consume a tag.
                    if (r_is_cfg) begin
                        r_tag_ctr <= r_tag_ctr + 8'd1;
                    end
                    r_seq_ctr <= r_seq_ctr + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        req_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = S_BEAT;
                end
            end
            S_BEAT: begin
                if (pg_s_axis_rq_tready && (r_beat == r_last_beat)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                req_done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_beat_data = '0;
        for (int b = 0; b < NB_PAY; b++) begin
            if (r_beat == 2'(b)) begin
                w_beat_data = r_tlp[b*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_keep = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            w_keep[k] = ((int'(r_beat) * DPB + k) < int'(r_ndw));
        end
    end

    // All stream outputs derive from registered state, so an asynchronous
    // reset clears them immediately.
    assign w_in_beat           = (r_state == S_BEAT);
    assign pg_s_axis_rq_tvalid = w_in_beat;
    assign pg_s_axis_rq_tdata  = w_in_beat ? w_beat_data : '0;
    assign pg_s_axis_rq_tkeep  = w_in_beat ? w_keep : '0;
    assign pg_s_axis_rq_tlast  = w_in_beat && (r_beat == r_last_beat);
    assign pg_s_axis_rq_tuser  = (w_in_beat && (r_beat == 2'd0)) ? r_tuser : '0;
    assign req_done_tag        = (r_state == S_DONE) ? r_tag : 8'h00;
    assign o_dbg_state         = r_state;

endmodule
